// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor: FSM state encoding
// and the counter-width function.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Number of bits needed to hold any value in [0, v-1].
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
// The overflow signal exists only when SERIAL_SUB_OVERFLOW_EN is defined.
interface serial_subtractor_if #(parameter int WIDTH = 4);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             overflow;
`endif

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
        , input overflow
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
        , output overflow
`endif
    );

endinterface

// File: rtl/serial_subtractor_bit_cell.sv
// Combinational full-subtractor cell: one bit of a - b with borrow in/out.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one full-subtractor cell and a registered borrow.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed overflow output.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_subtractor_if.slave bus
);

    localparam int             CW   = clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_e           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_acc, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_br, r_borrow;
    logic             w_d, w_bout, w_load, w_last;
    logic [WIDTH-1:0] w_res;

    sub_bit_cell u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // Operands are accepted from IDLE and also from DONE for back-to-back use.
    assign w_load = (r_state != ST_SHIFT) && bus.start;
    assign w_last = (r_state == ST_SHIFT) && (r_cnt == LAST);
    assign w_res  = {w_d, r_acc[WIDTH-1:1]};

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
            ST_SHIFT: if (r_cnt == LAST) w_next = ST_DONE;
            ST_DONE:  w_next = bus.start ? ST_SHIFT : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_borrow <= 1'b0;
        end else if (w_load) begin
            r_a   <= bus.a;
            r_b   <= bus.b;
            r_br  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == ST_SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_br  <= w_bout;
            r_acc <= w_res;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff   <= w_res;
                r_borrow <= w_bout;
            end
        end
    end

`ifdef SERIAL_SUB_OVERFLOW_EN
    logic r_a_msb, r_b_msb, r_ovf;

    // Operand MSBs are kept separately since the shift registers lose them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_load) begin
            r_a_msb <= bus.a[WIDTH-1];
            r_b_msb <= bus.b[WIDTH-1];
        end else if (w_last) begin
            r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
        end
    end

    assign bus.overflow = r_ovf;
`endif

    assign bus.busy   = (r_state == ST_SHIFT);
    assign bus.done   = (r_state == ST_DONE);
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases, random traffic
// and an exhaustive back-to-back sweep against a cycle-level reference model.
module tb_serial_subtractor;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int sgn(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    // Reference model: remaining bit count, pending operands, held results.
    int m_left = 0, m_a = 0, m_b = 0;
    int m_done = 0, m_diff = 0, m_borrow = 0, m_ovf = 0;
    bit exh = 1'b0;
    int last_done = -1;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_left = 0; m_done = 0; m_diff = 0; m_borrow = 0; m_ovf = 0;
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_diff", bus.diff, 0);
            chk("rst_borrow", bus.borrow, 0);
        end else begin
            chk("busy", bus.busy, (m_left > 0) ? 1 : 0);
            chk("done", bus.done, m_done);
            chk("diff", bus.diff, m_diff);
            chk("borrow", bus.borrow, m_borrow);
`ifdef SERIAL_SUB_OVERFLOW_EN
            chk("overflow", bus.overflow, m_ovf);
`endif
            if (exh && bus.done) begin
                if (last_done >= 0) chk("spacing", cyc - last_done, W + 1);
                last_done = cyc;
            end
            if (m_left > 0) begin
                m_left--;
                m_done = (m_left == 0) ? 1 : 0;
                if (m_done == 1) begin
                    m_diff   = (m_a - m_b) & MASK;
                    m_borrow = (m_a < m_b) ? 1 : 0;
                    m_ovf    = ((sgn(m_a) - sgn(m_b) < -HALF) ||
                                (sgn(m_a) - sgn(m_b) > HALF - 1)) ? 1 : 0;
                end
            end else begin
                m_done = 0;
                if (bus.start) begin
                    m_a    = int'(bus.a);
                    m_b    = int'(bus.b);
                    m_left = W;
                end
            end
        end
    end

    task automatic wait_done(input string nm, input int n0, input int ed, input int eb);
        int n, bc;
        n = n0; bc = n0;
        while (!bus.done && n < 20) begin
            if (bus.busy) bc++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_latency"}, n, W);
        chk({nm, "_busycnt"}, bc, W);
        chk({nm, "_diff"}, bus.diff, ed);
        chk({nm, "_borrow"}, bus.borrow, eb);
    endtask

    task automatic do_op(input int a, input int b, input int ed, input int eb,
                         input int eo, input string nm);
        @(posedge clk); #1;
        bus.a = W'(a); bus.b = W'(b); bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done(nm, 0, ed, eb);
`ifdef SERIAL_SUB_OVERFLOW_EN
        chk({nm, "_ovf"}, bus.overflow, eo);
`else
        if (eo < 0) chk({nm, "_ovf_arg"}, eo, 0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, pbusy;
        bit got;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #3;
        chk("init_busy", bus.busy, 0);
        chk("init_done", bus.done, 0);
        chk("init_diff", bus.diff, 0);
        chk("init_borrow", bus.borrow, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        do_op(5, 3, 2, 0, 0, "a5b3");
        do_op(3, 5, 14, 1, 0, "a3b5");
        do_op(0, 0, 0, 0, 0, "a0b0");
        do_op(15, 15, 0, 0, 0, "a15b15");
        do_op(8, 1, 7, 0, 1, "a8b1");
        do_op(2, 1, 1, 0, 0, "a2b1");

        // A second start while shifting must not disturb the running operation.
        @(posedge clk); #1;
        bus.a = 4'd9; bus.b = 4'd4; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        bus.a = 4'd1; bus.b = 4'd7; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_done("midstart", 2, 5, 0);

        // Asynchronous reset in the second shift cycle.
        @(posedge clk); #1;
        bus.a = 4'd6; bus.b = 4'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_diff", bus.diff, 0);
        chk("arst_borrow", bus.borrow, 0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("arst_no_done", bus.done, 0);
        do_op(12, 5, 7, 0, 1, "after_rst");

        repeat (300) begin
            @(posedge clk); #1;
            bus.start = ($urandom_range(0, 3) == 0);
            bus.a = W'($urandom);
            bus.b = W'($urandom);
        end
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Exhaustive sweep with start held high throughout.
        exh = 1'b1;
        last_done = -1;
        pbusy = bus.busy;
        bus.start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.a = W'(i >> 4);
            bus.b = W'(i & MASK);
            n = 0; got = 1'b0;
            while (n < 20 && !got) begin
                @(posedge clk); #1;
                n++;
                if (bus.busy && pbusy == 0) got = 1'b1;
                pbusy = bus.busy;
            end
            if (!got) chk("exh_accept", 0, 1);
        end
        bus.start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        exh = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
